// File: rtl/mig_cmd_ctrl_pkg.sv
// Shared types and constants for the MIG command controller: FSM state
// encoding, MIG app_cmd codes and the request record popped from the
// apb2mig FIFO.
package mig_cmd_ctrl_pkg;

   localparam int MCC_ADDR_W     = 27;
   localparam int MCC_APB_DATA_W = 32;
   localparam int MCC_APP_DATA_W = 128;
   localparam int MCC_STRB_W     = MCC_APB_DATA_W / 8;
   localparam int MCC_LANES      = MCC_APP_DATA_W / MCC_APB_DATA_W;
   localparam int MCC_LANE_W     = $clog2(MCC_LANES);

   localparam logic [2:0] APP_CMD_WRITE = 3'b000;
   localparam logic [2:0] APP_CMD_READ  = 3'b001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_CMD,
      ST_RD_DATA,
      ST_RSP
   } state_e;

   typedef struct packed {
      logic                      write;
      logic [MCC_ADDR_W:0]       addr;
      logic [MCC_APB_DATA_W-1:0] wdata;
      logic [MCC_STRB_W-1:0]     strb;
   } mig_req_t;

   // 32-bit lane inside the 128-bit MIG word addressed by a byte address.
   function automatic logic [MCC_LANE_W-1:0] addr_lane(input logic [MCC_ADDR_W:0] addr);
      return addr[MCC_LANE_W+1:2];
   endfunction

endpackage

// File: rtl/mig_cmd_ctrl_lane_sel.sv
// Lane steering between the 32-bit request side and the 128-bit MIG side:
// write data is replicated to every lane, the write mask enables only the
// strobed bytes of the selected lane, and read data is narrowed to one lane.
module mig_lane_sel #(
   parameter  int APB_DATA_W = 32,
   parameter  int APP_DATA_W = 128,
   localparam int LANES      = APP_DATA_W / APB_DATA_W,
   localparam int STRB_W     = APB_DATA_W / 8,
   localparam int APP_MASK_W = APP_DATA_W / 8,
   localparam int LANE_W     = $clog2(LANES)
) (
   input  logic [LANE_W-1:0]     wr_lane_i,
   input  logic [APB_DATA_W-1:0] wdata_i,
   input  logic [STRB_W-1:0]     strb_i,
   input  logic [LANE_W-1:0]     rd_lane_i,
   input  logic [APP_DATA_W-1:0] rd_data_i,
   output logic [APP_DATA_W-1:0] wdf_data_o,
   output logic [APP_MASK_W-1:0] wdf_mask_o,
   output logic [APB_DATA_W-1:0] rd_word_o
);

   logic [APB_DATA_W-1:0] rd_lanes [LANES];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign wdf_data_o[gi*APB_DATA_W +: APB_DATA_W] = wdata_i;
      // Mask bit 1 means "do not write"; only the addressed lane is opened.
      assign wdf_mask_o[gi*STRB_W +: STRB_W] =
         (wr_lane_i == LANE_W'(gi)) ? ~strb_i : {STRB_W{1'b1}};
      assign rd_lanes[gi] = rd_data_i[gi*APB_DATA_W +: APB_DATA_W];
   end

   assign rd_word_o = rd_lanes[rd_lane_i];

endmodule

// File: rtl/mig_cmd_ctrl.sv
// MIG command controller: pops one request from the apb2mig FIFO, issues a
// single-beat MIG write or read, and pushes read data into the mig2apb FIFO.
// Only one MIG transaction is outstanding at a time.
// Optional embedded assertions are compiled in with MIG_CMD_CTRL_SVA_EN.
module mig_cmd_ctrl
   import mig_cmd_ctrl_pkg::*;
#(
   parameter  int ADDR_W     = MCC_ADDR_W,
   parameter  int APB_DATA_W = MCC_APB_DATA_W,
   parameter  int APP_DATA_W = MCC_APP_DATA_W,
   localparam int APP_MASK_W = APP_DATA_W / 8,
   localparam int STRB_W     = APB_DATA_W / 8
) (
   input  logic                  ui_clk_i,
   input  logic                  ui_clk_sync_rst_i,
   input  logic                  init_calib_complete_i,
   input  logic                  req_empty_i,
   output logic                  req_rd_en_o,
   input  logic                  req_write_i,
   input  logic [ADDR_W:0]       req_addr_i,
   input  logic [APB_DATA_W-1:0] req_wdata_i,
   input  logic [STRB_W-1:0]     req_strb_i,
   input  logic                  rsp_full_i,
   output logic                  rsp_wr_en_o,
   output logic [APB_DATA_W-1:0] rsp_wdata_o,
   output logic [ADDR_W-1:0]     app_addr_o,
   output logic [2:0]            app_cmd_o,
   output logic                  app_en_o,
   input  logic                  app_rdy_i,
   output logic [APP_DATA_W-1:0] app_wdf_data_o,
   output logic [APP_MASK_W-1:0] app_wdf_mask_o,
   output logic                  app_wdf_wren_o,
   output logic                  app_wdf_end_o,
   input  logic                  app_wdf_rdy_i,
   input  logic [APP_DATA_W-1:0] app_rd_data_i,
   input  logic                  app_rd_data_valid_i
);

   state_e                state_q,     state_d;
   mig_req_t              req_q,       req_d;
   logic                  cmd_done_q,  cmd_done_d;
   logic                  wdf_done_q,  wdf_done_d;
   logic [APP_DATA_W-1:0] wdf_data_q,  wdf_data_d;
   logic [APP_MASK_W-1:0] wdf_mask_q,  wdf_mask_d;
   logic [APB_DATA_W-1:0] rsp_data_q,  rsp_data_d;

   mig_req_t              req_in;
   logic [APP_DATA_W-1:0] lane_wdf_data;
   logic [APP_MASK_W-1:0] lane_wdf_mask;
   logic [APB_DATA_W-1:0] lane_rd_word;
   logic                  cmd_acc;
   logic                  wdf_acc;
   logic                  unused_req_bits;

   assign req_in.write = req_write_i;
   assign req_in.addr  = req_addr_i;
   assign req_in.wdata = req_wdata_i;
   assign req_in.strb  = req_strb_i;

   // Write data/mask are built from the FIFO head at pop time and held in
   // registers; read lane selection uses the registered request address.
   mig_lane_sel #(
      .APB_DATA_W (APB_DATA_W),
      .APP_DATA_W (APP_DATA_W)
   ) u_lane_sel (
      .wr_lane_i  (addr_lane(req_in.addr)),
      .wdata_i    (req_in.wdata),
      .strb_i     (req_in.strb),
      .rd_lane_i  (addr_lane(req_q.addr)),
      .rd_data_i  (app_rd_data_i),
      .wdf_data_o (lane_wdf_data),
      .wdf_mask_o (lane_wdf_mask),
      .rd_word_o  (lane_rd_word)
   );

   // MIG addresses are in 16-bit column units, aligned to a BL8 burst.
   assign app_addr_o     = {req_q.addr[ADDR_W:4], 3'b000};
   assign app_wdf_data_o = wdf_data_q;
   assign app_wdf_mask_o = wdf_mask_q;
   assign rsp_wdata_o    = rsp_data_q;

   // Only the address, data and lane are consumed after the pop; the type
   // is carried in the FSM state and the strobes in the registered mask.
   assign unused_req_bits = ^{req_q.write, req_q.wdata, req_q.strb, req_q.addr[1:0]};

   assign cmd_acc = cmd_done_q | app_rdy_i;
   assign wdf_acc = wdf_done_q | app_wdf_rdy_i;

   // Next-state and output decode; FIFO pop/push are suppressed in reset.
   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      cmd_done_d     = cmd_done_q;
      wdf_done_d     = wdf_done_q;
      wdf_data_d     = wdf_data_q;
      wdf_mask_d     = wdf_mask_q;
      rsp_data_d     = rsp_data_q;
      req_rd_en_o    = 1'b0;
      rsp_wr_en_o    = 1'b0;
      app_en_o       = 1'b0;
      app_cmd_o      = APP_CMD_WRITE;
      app_wdf_wren_o = 1'b0;
      app_wdf_end_o  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (init_calib_complete_i && !req_empty_i && !ui_clk_sync_rst_i) begin
               req_rd_en_o = 1'b1;
               req_d       = req_in;
               wdf_data_d  = lane_wdf_data;
               wdf_mask_d  = lane_wdf_mask;
               cmd_done_d  = 1'b0;
               wdf_done_d  = 1'b0;
               state_d     = req_write_i ? ST_WR : ST_RD_CMD;
            end
         end
         ST_WR: begin
            // Command and write-data channels handshake independently.
            app_en_o       = !cmd_done_q;
            app_cmd_o      = APP_CMD_WRITE;
            app_wdf_wren_o = !wdf_done_q;
            app_wdf_end_o  = !wdf_done_q;
            if (cmd_acc && wdf_acc) begin
               cmd_done_d = 1'b0;
               wdf_done_d = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               cmd_done_d = cmd_acc;
               wdf_done_d = wdf_acc;
            end
         end
         ST_RD_CMD: begin
            app_en_o  = 1'b1;
            app_cmd_o = APP_CMD_READ;
            if (app_rdy_i) begin
               state_d = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (app_rd_data_valid_i) begin
               rsp_data_d = lane_rd_word;
               state_d    = ST_RSP;
            end
         end
         ST_RSP: begin
            // Response data is held until the FIFO has room.
            if (!rsp_full_i && !ui_clk_sync_rst_i) begin
               rsp_wr_en_o = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge ui_clk_i) begin
      if (ui_clk_sync_rst_i) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         cmd_done_q <= 1'b0;
         wdf_done_q <= 1'b0;
         wdf_data_q <= '0;
         wdf_mask_q <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         cmd_done_q <= cmd_done_d;
         wdf_done_q <= wdf_done_d;
         wdf_data_q <= wdf_data_d;
         wdf_mask_q <= wdf_mask_d;
         rsp_data_q <= rsp_data_d;
      end
   end

`ifdef MIG_CMD_CTRL_SVA_EN
   a_app_en_hold: assert property (@(posedge ui_clk_i) disable iff (ui_clk_sync_rst_i)
      app_en_o && !app_rdy_i |=> app_en_o && $stable(app_addr_o) && $stable(app_cmd_o));

   a_wdf_wren_hold: assert property (@(posedge ui_clk_i) disable iff (ui_clk_sync_rst_i)
      app_wdf_wren_o && !app_wdf_rdy_i |=> app_wdf_wren_o);

   a_no_push_full: assert property (@(posedge ui_clk_i) disable iff (ui_clk_sync_rst_i)
      !(rsp_wr_en_o && rsp_full_i));

   a_no_pop_empty: assert property (@(posedge ui_clk_i) disable iff (ui_clk_sync_rst_i)
      !(req_rd_en_o && req_empty_i));

   a_no_stray_rd_data: assert property (@(posedge ui_clk_i) disable iff (ui_clk_sync_rst_i)
      app_rd_data_valid_i |-> state_q == ST_RD_DATA)
      else $error("mig_cmd_ctrl: app_rd_data_valid_i outside RD_DATA");
`endif

endmodule

// File: tb/tb_mig_cmd_ctrl.sv
// Scoreboard bench for mig_cmd_ctrl: stimulus pushes expected MIG commands,
// write beats and responses into queues; a monitor pops and compares them
// whenever the DUT completes the matching handshake.
module tb_mig_cmd_ctrl;

   logic         clk = 1'b0;
   logic         srst;
   logic         calib;
   logic         req_empty;
   logic         req_rd_en;
   logic         req_write;
   logic [27:0]  req_addr;
   logic [31:0]  req_wdata;
   logic [3:0]   req_strb;
   logic         rsp_full;
   logic         rsp_wr_en;
   logic [31:0]  rsp_wdata;
   logic [26:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en;
   logic         app_rdy;
   logic [127:0] wdf_data;
   logic [15:0]  wdf_mask;
   logic         wdf_wren;
   logic         wdf_end;
   logic         wdf_rdy;
   logic [127:0] rd_data;
   logic         rd_valid;

   int errors = 0;
   int checks = 0;

   logic [29:0]  cmd_exp [$];
   logic [143:0] wdf_exp [$];
   logic [31:0]  rsp_exp [$];

   localparam logic [127:0] RD_PAT = 128'h44444444_33333333_22222222_11111111;

   always #5 clk = ~clk;

   mig_cmd_ctrl dut (
      .ui_clk_i              (clk),
      .ui_clk_sync_rst_i     (srst),
      .init_calib_complete_i (calib),
      .req_empty_i           (req_empty),
      .req_rd_en_o           (req_rd_en),
      .req_write_i           (req_write),
      .req_addr_i            (req_addr),
      .req_wdata_i           (req_wdata),
      .req_strb_i            (req_strb),
      .rsp_full_i            (rsp_full),
      .rsp_wr_en_o           (rsp_wr_en),
      .rsp_wdata_o           (rsp_wdata),
      .app_addr_o            (app_addr),
      .app_cmd_o             (app_cmd),
      .app_en_o              (app_en),
      .app_rdy_i             (app_rdy),
      .app_wdf_data_o        (wdf_data),
      .app_wdf_mask_o        (wdf_mask),
      .app_wdf_wren_o        (wdf_wren),
      .app_wdf_end_o         (wdf_end),
      .app_wdf_rdy_i         (wdf_rdy),
      .app_rd_data_i         (rd_data),
      .app_rd_data_valid_i   (rd_valid)
   );

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present_req(input logic wr, input logic [27:0] a,
                              input logic [31:0] d, input logic [3:0] s);
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_strb  = s;
      req_empty = 1'b0;
      #1;
   endtask

   // Monitor: compare each completed handshake against the queued expectation.
   always @(negedge clk) begin
      if (!srst) begin
         if (app_en && app_rdy) begin
            if (cmd_exp.size() == 0) check("cmd_unexpected", {app_addr, app_cmd}, 0);
            else check("cmd_addr_cmd", {app_addr, app_cmd}, cmd_exp.pop_front());
         end
         if (wdf_wren && wdf_rdy) begin
            check("wdf_end", wdf_end, 1);
            if (wdf_exp.size() == 0) check("wdf_unexpected", {wdf_data, wdf_mask}, 0);
            else check("wdf_data_mask", {wdf_data, wdf_mask}, wdf_exp.pop_front());
         end
         if (rsp_wr_en) begin
            check("push_while_full", rsp_full, 0);
            if (rsp_exp.size() == 0) check("rsp_unexpected", rsp_wdata, 0);
            else check("rsp_data", rsp_wdata, rsp_exp.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops, en_cnt, wren_cnt, pushes;
      srst = 1; calib = 0; req_empty = 1; req_write = 0; req_addr = 0;
      req_wdata = 0; req_strb = 0; rsp_full = 0; app_rdy = 0; wdf_rdy = 0;
      rd_data = 0; rd_valid = 0;
      repeat (3) tick();

      // Reset state
      check("rst_req_rd_en", req_rd_en, 0);
      check("rst_rsp_wr_en", rsp_wr_en, 0);
      check("rst_app_en", app_en, 0);
      check("rst_wdf_wren_end", {wdf_wren, wdf_end}, 0);
      check("rst_app_addr", app_addr, 0);
      check("rst_wdf_mask", wdf_mask, 0);
      check("rst_wdf_data", wdf_data, 0);
      check("rst_rsp_wdata", rsp_wdata, 0);
      srst = 0;
      tick();

      // Calibration gate, then write to lane 2 with strobes 0011
      app_rdy = 1; wdf_rdy = 1;
      present_req(1, 28'h18, 32'hDEADBEEF, 4'b0011);
      pops = 0;
      for (int k = 0; k < 20; k++) begin
         if (req_rd_en) pops++;
         tick();
      end
      check("calib_gate_pops", pops, 0);
      calib = 1; #1;
      check("calib_pop", req_rd_en, 1);
      cmd_exp.push_back({27'h8, 3'b000});
      wdf_exp.push_back({{4{32'hDEADBEEF}}, 16'hFCFF});
      tick(); req_empty = 1; #1;
      check("wr_pop_single", req_rd_en, 0);
      check("wr_app_en_latency", {app_en, wdf_wren}, 2'b11);
      tick();
      check("wr_back_idle", {app_en, wdf_wren}, 0);

      // Staggered write: data accepted at once, command after 5 cycles
      app_rdy = 0;
      present_req(1, 28'h30, 32'h12345678, 4'hF);
      check("stag_pop", req_rd_en, 1);
      cmd_exp.push_back({27'h18, 3'b000});
      wdf_exp.push_back({{4{32'h12345678}}, 16'hFFF0});
      tick(); req_empty = 1;
      en_cnt = 0; wren_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) app_rdy = 1;
         if (app_en) en_cnt++;
         if (wdf_wren) wren_cnt++;
         tick();
      end
      check("stag_app_en_cycles", en_cnt, 5);
      check("stag_wren_cycles", wren_cnt, 1);
      check("stag_back_idle", {app_en, wdf_wren}, 0);

      // Read lane 1, immediate pop on IDLE re-entry
      present_req(0, 28'h24, 32'h0, 4'h0);
      check("rd_pop", req_rd_en, 1);
      cmd_exp.push_back({27'h10, 3'b001});
      rsp_exp.push_back(32'h22222222);
      tick(); req_empty = 1;
      check("rd_cmd_issue", {app_en, app_cmd}, {1'b1, 3'b001});
      tick();
      check("rd_cmd_drop", app_en, 0);
      rd_data = RD_PAT; rd_valid = 1;
      tick(); rd_valid = 0;
      check("rd_push_latency", rsp_wr_en, 1);
      tick();
      check("rd_push_single", rsp_wr_en, 0);

      // Read lane 3 with the response FIFO full for 8 cycles
      present_req(0, 28'h0C, 32'h0, 4'h0);
      check("full_pop", req_rd_en, 1);
      cmd_exp.push_back({27'h0, 3'b001});
      rsp_exp.push_back(32'h44444444);
      tick(); req_empty = 1;
      tick();
      rsp_full = 1; rd_valid = 1;
      tick(); rd_valid = 0;
      pushes = 0;
      for (int k = 0; k < 8; k++) begin
         if (rsp_wr_en) pushes++;
         tick();
      end
      check("full_no_push", pushes, 0);
      check("full_data_held", rsp_wdata, 32'h44444444);
      rsp_full = 0; #1;
      check("full_release_push", rsp_wr_en, 1);
      tick();
      check("full_push_single", rsp_wr_en, 0);

      // Reset in RD_DATA, stray read data afterwards, then a normal read
      present_req(0, 28'h04, 32'h0, 4'h0);
      cmd_exp.push_back({27'h0, 3'b001});
      tick(); req_empty = 1;
      tick();
      srst = 1;
      tick(); srst = 0;
      check("mid_rst_outputs", {app_en, wdf_wren, rsp_wr_en, req_rd_en}, 0);
      check("mid_rst_rsp_wdata", rsp_wdata, 0);
      check("mid_rst_mask", wdf_mask, 0);
      rd_data = RD_PAT; rd_valid = 1;
      tick(); rd_valid = 0;
      pushes = 0;
      for (int k = 0; k < 4; k++) begin
         if (rsp_wr_en) pushes++;
         tick();
      end
      check("stray_no_push", pushes, 0);
      check("stray_data_ignored", rsp_wdata, 0);
      present_req(0, 28'h28, 32'h0, 4'h0);
      check("post_rst_pop", req_rd_en, 1);
      cmd_exp.push_back({27'h10, 3'b001});
      rsp_exp.push_back(32'h33333333);
      tick(); req_empty = 1;
      tick();
      rd_valid = 1;
      tick(); rd_valid = 0;
      check("post_rst_push", rsp_wr_en, 1);
      tick();

      check("cmd_queue_drained", cmd_exp.size(), 0);
      check("wdf_queue_drained", wdf_exp.size(), 0);
      check("rsp_queue_drained", rsp_exp.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
